decode_stage: RTL and testbench

Second stage of the pipelined processor: consumes the instruction word that main memory returns for the fetch stage's PC, decodes it (MIPS-I integer subset), reads the register file and registers operands plus control into the ID/EX pipeline register. It detects load-use hazards and drives the fetch stage's `stall_in`. It accepts a flush when a branch or jump resolves downstream (the same event that drives fetch's `update_pc`).

---
 rtl/cpu_pkg.sv | 74 +++++++
 rtl/regfile.sv | 46 ++++
 rtl/decode_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the pipelined MIPS-I integer core: opcodes, functs,
// ALU operation codes, immediate-extension kinds and the ID/EX control bundle.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_LINK = 5'd31;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_UPPER = 2'd2
    } imm_kind_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump;
        logic       jump_reg;
        logic       illegal;
        logic [4:0] dest;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero, and a same-cycle write-through bypass on both reads.
module regfile (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [4:0]  rs_addr_in,
    input  logic [4:0]  rt_addr_in,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_addr_in,
    input  logic [31:0] wb_data_in
);

    logic [31:0] mem_q [32];
    logic [31:0] mem_d [32];
    logic        wr_live;

    assign wr_live = wb_en_in & (wb_addr_in != 5'd0);

    always_comb begin
        mem_d = mem_q;
        if (wr_live) begin
            mem_d[wb_addr_in] = wb_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Bypass lets decode see a value being written back in the same cycle.
    assign rs_data_out = (rs_addr_in == 5'd0)                     ? 32'h0      :
                         (wr_live && (wb_addr_in == rs_addr_in))  ? wb_data_in :
                                                                    mem_q[rs_addr_in];
    assign rt_data_out = (rt_addr_in == 5'd0)                     ? 32'h0      :
                         (wr_live && (wb_addr_in == rt_addr_in))  ? wb_data_in :
                                                                    mem_q[rt_addr_in];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes the fetched word, reads operands, detects
// load-use hazards and registers everything into the ID/EX pipeline register.
module decode_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] insn_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic        insn_valid_in,
    input  logic        flush_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_out,
    output logic [4:0]  shamt_out,
    output logic [4:0]  dest_out,
    output logic [3:0]  alu_op_out,
    output logic        alu_src_imm_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        reg_write_out,
    output logic        branch_eq_out,
    output logic        branch_ne_out,
    output logic        jump_out,
    output logic        jump_reg_out,
    output logic        illegal_out,
    output logic [31:0] target_out
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [31:0] imm_sx;

    assign op     = insn_in[31:26];
    assign rs     = insn_in[25:21];
    assign rt     = insn_in[20:16];
    assign rd     = insn_in[15:11];
    assign fn     = insn_in[5:0];
    assign imm16  = insn_in[15:0];
    assign imm_sx = sext16(imm16);

    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;

    regfile u_regfile (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rs_addr_in  (rs),
        .rt_addr_in  (rt),
        .rs_data_out (rf_rs_data),
        .rt_data_out (rf_rt_data),
        .wb_en_in    (wb_en_in),
        .wb_addr_in  (wb_addr_in),
        .wb_data_in  (wb_data_in)
    );

    ctrl_t       dec;
    logic        dec_writes;
    logic        reads_rt;
    imm_kind_e   imm_kind;
    logic [31:0] dec_imm;
    logic [31:0] dec_target;

    always_comb begin
        dec        = '0;
        dec_writes = 1'b0;
        reads_rt   = 1'b0;
        imm_kind   = IMM_SIGN;
        case (op)
            OP_RTYPE: begin
                reads_rt   = 1'b1;
                dec.dest   = rd;
                dec_writes = 1'b1;
                case (fn)
                    FN_SLL:          dec.alu_op = ALU_SLL;
                    FN_SRL:          dec.alu_op = ALU_SRL;
                    FN_SRA:          dec.alu_op = ALU_SRA;
                    FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:          dec.alu_op = ALU_AND;
                    FN_OR:           dec.alu_op = ALU_OR;
                    FN_XOR:          dec.alu_op = ALU_XOR;
                    FN_NOR:          dec.alu_op = ALU_NOR;
                    FN_SLT:          dec.alu_op = ALU_SLT;
                    FN_SLTU:         dec.alu_op = ALU_SLTU;
                    FN_JR: begin
                        dec.jump_reg = 1'b1;
                        dec.dest     = REG_ZERO;
                        dec_writes   = 1'b0;
                    end
                    default: begin
                        dec.illegal = 1'b1;
                        dec.dest    = REG_ZERO;
                        dec_writes  = 1'b0;
                    end
                endcase
            end
            OP_J: dec.jump = 1'b1;
            OP_JAL: begin
                dec.jump   = 1'b1;
                dec.dest   = REG_LINK;
                dec_writes = 1'b1;
            end
            OP_BEQ: begin
                dec.branch_eq = 1'b1;
                dec.alu_op    = ALU_SUB;
                reads_rt      = 1'b1;
            end
            OP_BNE: begin
                dec.branch_ne = 1'b1;
                dec.alu_op    = ALU_SUB;
                reads_rt      = 1'b1;
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.alu_src_imm = 1'b1;
                dec.dest        = rt;
                dec_writes      = 1'b1;
                case (op)
                    OP_SLTI: dec.alu_op = ALU_SLT;
                    OP_ANDI: begin dec.alu_op = ALU_AND; imm_kind = IMM_ZERO;  end
                    OP_ORI:  begin dec.alu_op = ALU_OR;  imm_kind = IMM_ZERO;  end
                    OP_XORI: begin dec.alu_op = ALU_XOR; imm_kind = IMM_ZERO;  end
                    OP_LUI:  begin dec.alu_op = ALU_LUI; imm_kind = IMM_UPPER; end
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec.alu_src_imm = 1'b1;
                dec.mem_read    = 1'b1;
                dec.dest        = rt;
                dec_writes      = 1'b1;
            end
            OP_SW: begin
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
                reads_rt        = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // A zero destination never writes, which turns NOP into a harmless SLL.
        dec.reg_write = dec_writes & (dec.dest != REG_ZERO);
    end

    always_comb begin
        case (imm_kind)
            IMM_ZERO:  dec_imm = {16'h0, imm16};
            IMM_UPPER: dec_imm = {imm16, 16'h0};
            default:   dec_imm = imm_sx;
        endcase
    end

    assign dec_target = dec.jump ? {next_pc_in[31:28], insn_in[25:0], 2'b00}
                                 : next_pc_in + {imm_sx[29:0], 2'b00};

    logic        valid_q,    valid_d;
    ctrl_t       ctrl_q,     ctrl_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] next_pc_q,  next_pc_d;
    logic [31:0] rs_data_q,  rs_data_d;
    logic [31:0] rt_data_q,  rt_data_d;
    logic [31:0] imm_q,      imm_d;
    logic [4:0]  shamt_q,    shamt_d;
    logic [31:0] target_q,   target_d;
    logic        load_use;
    logic        issue;

    // The load in ID/EX has no data until MEM, so a dependent reader must wait one bubble.
    assign load_use = valid_q & ctrl_q.mem_read & (ctrl_q.dest != REG_ZERO) & insn_valid_in &
                      ((ctrl_q.dest == rs) | ((ctrl_q.dest == rt) & reads_rt));

    // Fetch re-presents the same word while stall_out is high; flush and stall both bubble.
    assign issue = insn_valid_in & ~flush_in & ~load_use;

    always_comb begin
        valid_d   = issue;
        ctrl_d    = issue ? dec : '0;
        pc_d      = pc_in;
        next_pc_d = next_pc_in;
        rs_data_d = rf_rs_data;
        rt_data_d = rf_rt_data;
        imm_d     = dec_imm;
        shamt_d   = insn_in[10:6];
        target_d  = dec_target;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            shamt_q   <= '0;
            target_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            shamt_q   <= shamt_d;
            target_q  <= target_d;
        end
    end

    assign stall_out       = load_use;
    assign valid_out       = valid_q;
    assign pc_out          = pc_q;
    assign next_pc_out     = next_pc_q;
    assign rs_data_out     = rs_data_q;
    assign rt_data_out     = rt_data_q;
    assign imm_out         = imm_q;
    assign shamt_out       = shamt_q;
    assign target_out      = target_q;
    assign dest_out        = ctrl_q.dest;
    assign alu_op_out      = ctrl_q.alu_op;
    assign alu_src_imm_out = ctrl_q.alu_src_imm;
    assign mem_read_out    = ctrl_q.mem_read;
    assign mem_write_out   = ctrl_q.mem_write;
    assign reg_write_out   = ctrl_q.reg_write;
    assign branch_eq_out   = ctrl_q.branch_eq;
    assign branch_ne_out   = ctrl_q.branch_ne;
    assign jump_out        = ctrl_q.jump;
    assign jump_reg_out    = ctrl_q.jump_reg;
    assign illegal_out     = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps followed by random instruction streams,
// each checked against an instruction-level reference model of decode.
module tb_decode_stage;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] insn_in, pc_in, next_pc_in;
    logic        insn_valid_in, flush_in, wb_en_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        stall_out, valid_out;
    logic [31:0] pc_out, next_pc_out, rs_data_out, rt_data_out, imm_out, target_out;
    logic [4:0]  shamt_out, dest_out;
    logic [3:0]  alu_op_out;
    logic        alu_src_imm_out, mem_read_out, mem_write_out, reg_write_out;
    logic        branch_eq_out, branch_ne_out, jump_out, jump_reg_out, illegal_out;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .insn_in(insn_in), .pc_in(pc_in),
        .next_pc_in(next_pc_in), .insn_valid_in(insn_valid_in), .flush_in(flush_in),
        .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .stall_out(stall_out), .valid_out(valid_out), .pc_out(pc_out),
        .next_pc_out(next_pc_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
        .imm_out(imm_out), .shamt_out(shamt_out), .dest_out(dest_out),
        .alu_op_out(alu_op_out), .alu_src_imm_out(alu_src_imm_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .reg_write_out(reg_write_out), .branch_eq_out(branch_eq_out),
        .branch_ne_out(branch_ne_out), .jump_out(jump_out), .jump_reg_out(jump_reg_out),
        .illegal_out(illegal_out), .target_out(target_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, npc, rs_d, rt_d, imm, target;
        logic [4:0]  shamt, dest;
        logic [3:0]  alu;
        logic        src, mr, mw, rw, beq, bne, j, jr, ill;
        logic        chk_alu, chk_src, has_tgt;
    } exp_t;

    localparam logic [5:0] R_FN [14] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22,
                                         6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    localparam logic [5:0] I_OP [12] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A,
                                         6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rf_m [32];
    exp_t        cur;
    logic        obs_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return rf_m[a];
    endfunction

    function automatic logic reads_rt(input logic [31:0] insn);
        logic [5:0] op;
        op = insn[31:26];
        return (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    endfunction

    // Instruction-level meaning of each supported encoding.
    function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] npc);
        exp_t        e;
        logic [5:0]  op, fn;
        logic [4:0]  rt, rd;
        logic [15:0] i16;
        logic [31:0] sx;
        logic        wr;
        op  = insn[31:26];
        fn  = insn[5:0];
        rt  = insn[20:16];
        rd  = insn[15:11];
        i16 = insn[15:0];
        sx  = {{16{i16[15]}}, i16};
        e = '0;
        e.valid = 1'b1;
        e.shamt = insn[10:6];
        e.imm   = sx;
        wr = 1'b0;
        if (op == 6'h00) begin
            e.dest = rd; wr = 1'b1; e.chk_alu = 1'b1; e.chk_src = 1'b1;
            case (fn)
                6'h00: e.alu = ALU_SLL;
                6'h02: e.alu = ALU_SRL;
                6'h03: e.alu = ALU_SRA;
                6'h20, 6'h21: e.alu = ALU_ADD;
                6'h22, 6'h23: e.alu = ALU_SUB;
                6'h24: e.alu = ALU_AND;
                6'h25: e.alu = ALU_OR;
                6'h26: e.alu = ALU_XOR;
                6'h27: e.alu = ALU_NOR;
                6'h2A: e.alu = ALU_SLT;
                6'h2B: e.alu = ALU_SLTU;
                6'h08: begin e.jr = 1'b1; e.dest = 5'd0; wr = 1'b0; e.chk_alu = 1'b0; e.chk_src = 1'b0; end
                default: begin e.ill = 1'b1; e.dest = 5'd0; wr = 1'b0; e.chk_alu = 1'b0; e.chk_src = 1'b0; end
            endcase
        end else begin
            case (op)
                6'h02, 6'h03: begin
                    e.j = 1'b1; e.has_tgt = 1'b1;
                    e.target = {npc[31:28], insn[25:0], 2'b00};
                    if (op == 6'h03) begin e.dest = 5'd31; wr = 1'b1; end
                end
                6'h04, 6'h05: begin
                    e.beq = (op == 6'h04); e.bne = (op == 6'h05); e.has_tgt = 1'b1;
                    e.target = npc + (sx << 2);
                end
                6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                    e.dest = rt; wr = 1'b1; e.src = 1'b1; e.chk_alu = 1'b1; e.chk_src = 1'b1;
                    case (op)
                        6'h09: e.alu = ALU_ADD;
                        6'h0A: e.alu = ALU_SLT;
                        6'h0C: begin e.alu = ALU_AND; e.imm = {16'h0, i16}; end
                        6'h0D: begin e.alu = ALU_OR;  e.imm = {16'h0, i16}; end
                        6'h0E: begin e.alu = ALU_XOR; e.imm = {16'h0, i16}; end
                        default: begin e.alu = ALU_LUI; e.imm = {i16, 16'h0}; end
                    endcase
                end
                6'h23: begin e.mr = 1'b1; e.dest = rt; wr = 1'b1; e.src = 1'b1; e.alu = ALU_ADD; e.chk_alu = 1'b1; e.chk_src = 1'b1; end
                6'h2B: begin e.mw = 1'b1; e.src = 1'b1; e.alu = ALU_ADD; e.chk_alu = 1'b1; e.chk_src = 1'b1; end
                default: e.ill = 1'b1;
            endcase
        end
        e.rw = wr && (e.dest != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [4:0]  s, t, d;
        int          k;
        r = $urandom;
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 99);
        if (k < 4)  return {6'h3F, r[25:0]};
        if (k < 7)  return {6'h00, s, t, d, r[10:6], 6'h01};
        if (k < 10) return 32'h0;
        if (k < 50) return {6'h00, s, t, d, r[10:6], R_FN[$urandom_range(0, 13)]};
        return {I_OP[$urandom_range(0, 11)], s, t, r[15:0]};
    endfunction

    task automatic compare(input exp_t e);
        check1("valid", valid_out, e.valid);
        check1("reg_write", reg_write_out, e.rw);
        check1("mem_read", mem_read_out, e.mr);
        check1("mem_write", mem_write_out, e.mw);
        check1("branch_eq", branch_eq_out, e.beq);
        check1("branch_ne", branch_ne_out, e.bne);
        check1("jump", jump_out, e.j);
        check1("jump_reg", jump_reg_out, e.jr);
        if (e.valid) begin
            check("pc", pc_out, e.pc);
            check("next_pc", next_pc_out, e.npc);
            check("rs_data", rs_data_out, e.rs_d);
            check("rt_data", rt_data_out, e.rt_d);
            check("imm", imm_out, e.imm);
            check("shamt", 32'(shamt_out), 32'(e.shamt));
            check("dest", 32'(dest_out), 32'(e.dest));
            check1("illegal", illegal_out, e.ill);
            if (e.chk_alu) check("alu_op", 32'(alu_op_out), 32'(e.alu));
            if (e.chk_src) check1("alu_src_imm", alu_src_imm_out, e.src);
            if (e.has_tgt) check("target", target_out, e.target);
        end
    endtask

    // Entered at posedge+1; leaves at the following posedge+1.
    task automatic step(input logic [31:0] insn, input logic iv, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [31:0] pc);
        exp_t nxt;
        logic exp_stall;
        logic [4:0] rs_a, rt_a;
        rs_a = insn[25:21];
        rt_a = insn[20:16];
        insn_in = insn; insn_valid_in = iv; flush_in = fl;
        wb_en_in = we; wb_addr_in = wa; wb_data_in = wd;
        pc_in = pc; next_pc_in = pc + 32'd4;
        #1;
        exp_stall = cur.valid && cur.mr && (cur.dest != 5'd0) && iv &&
                    ((cur.dest == rs_a) || ((cur.dest == rt_a) && reads_rt(insn)));
        obs_stall = stall_out;
        check1("stall", stall_out, exp_stall);
        if (fl || exp_stall || !iv) begin
            nxt = '0;
        end else begin
            nxt = ref_decode(insn, pc + 32'd4);
            nxt.pc   = pc;
            nxt.npc  = pc + 32'd4;
            nxt.rs_d = rf_read(rs_a, we, wa, wd);
            nxt.rt_d = rf_read(rt_a, we, wa, wd);
        end
        @(posedge clk_in);
        if (we && wa != 5'd0) rf_m[wa] = wd;
        #1;
        compare(nxt);
        cur = nxt;
    endtask

    task automatic drive_idle();
        insn_in = 32'h0; pc_in = 32'h0; next_pc_in = 32'h0;
        insn_valid_in = 1'b0; flush_in = 1'b0;
        wb_en_in = 1'b0; wb_addr_in = 5'd0; wb_data_in = 32'h0;
    endtask

    task automatic check_reset_outputs();
        check1("rst_valid", valid_out, 1'b0);
        check("rst_pc", pc_out, RST_PC);
        check("rst_next_pc", next_pc_out, RST_PC);
        check("rst_rs_data", rs_data_out, 32'h0);
        check("rst_rt_data", rt_data_out, 32'h0);
        check("rst_imm", imm_out, 32'h0);
        check("rst_target", target_out, 32'h0);
        check("rst_fields", {18'h0, shamt_out, dest_out, alu_op_out}, 32'h0);
        check("rst_flags", {23'h0, alu_src_imm_out, mem_read_out, mem_write_out, reg_write_out,
                            branch_eq_out, branch_ne_out, jump_out, jump_reg_out, illegal_out}, 32'h0);
        check1("rst_stall", stall_out, 1'b0);
    endtask

    task automatic model_reset();
        cur = '0;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    endtask

    logic [31:0] held_insn;
    logic [31:0] held_pc;

    initial begin
        rst_n_in = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_outputs();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // ADD r2,r4,r5 with r4=3, r5=4
        step(32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 32'd3, 32'h0);
        step(32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd4, 32'h0);
        step(32'h0085_1020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_0200);
        check("add_alu", 32'(alu_op_out), 32'(ALU_ADD));
        check("add_rs", rs_data_out, 32'd3);
        check("add_rt", rt_data_out, 32'd4);
        check("add_dest", 32'(dest_out), 32'd2);
        check1("add_rw", reg_write_out, 1'b1);

        // LW r8,4(r9) followed by ADDU r10,r8,r0: one stall, a bubble, then issue
        step(32'h8D28_0004, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_1000, 32'h0000_0204);
        step(32'h0100_5021, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_0208);
        check1("lu_stall_hi", obs_stall, 1'b1);
        check1("lu_bubble", valid_out, 1'b0);
        step(32'h0100_5021, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_0208);
        check1("lu_stall_lo", obs_stall, 1'b0);
        check1("lu_issue", valid_out, 1'b1);

        // ORI zero-extends, ADDIU sign-extends
        step(32'h3403_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_020C);
        check("ori_imm", imm_out, 32'h0000_FFFF);
        step(32'h2403_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_0210);
        check("addiu_imm", imm_out, 32'hFFFF_FFFF);

        // BEQ imm=-1 at next_pc 0x104, then the same with a flush
        step(32'h1022_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_0100);
        check("beq_target", target_out, 32'h0000_0100);
        check1("beq_flag", branch_eq_out, 1'b1);
        step(32'h1022_FFFF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_0100);
        check1("flush_valid", valid_out, 1'b0);
        check1("flush_beq", branch_eq_out, 1'b0);

        // Bypass of a same-cycle write to r7; writes to r0 are dropped
        step(32'h00E0_0821, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_DEAD, 32'h0000_0300);
        check("bypass_rs", rs_data_out, 32'h0000_DEAD);
        step(32'h0000_0821, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234_5678, 32'h0000_0304);
        check("r0_bypass", rs_data_out, 32'h0);
        step(32'h0000_0821, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_0308);
        check("r0_read", rs_data_out, 32'h0);

        // Unknown opcode
        step(32'hFC00_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_030C);
        check1("illegal_flag", illegal_out, 1'b1);
        check1("illegal_rw", reg_write_out, 1'b0);

        // Random stream; a stalled word is re-presented as fetch would
        held_insn = 32'h0;
        held_pc   = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (!obs_stall) begin
                held_insn = rand_insn();
                held_pc   = $urandom & 32'hFFFF_FFFC;
            end
            step(held_insn, ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom, held_pc);
        end

        // Asynchronous reset in mid-cycle, then r5 must read back as zero
        step(32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_0055, 32'h0);
        drive_idle();
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        step(32'h00A0_0821, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_0400);
        check("post_rst_r5", rs_data_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
